// File: rtl/qbus_dl11_pkg.sv
// Shared definitions for the DL11 console terminal slave: register offsets,
// CSR bit positions, bus FSM states and the default vectors.
package qbus_dl11_pkg;

  localparam logic [1:0] REG_RCSR = 2'd0;
  localparam logic [1:0] REG_RBUF = 2'd1;
  localparam logic [1:0] REG_XCSR = 2'd2;
  localparam logic [1:0] REG_XBUF = 2'd3;

  localparam int RCSR_DONE  = 7;
  localparam int RCSR_IE    = 6;
  localparam int RBUF_ERR   = 15;
  localparam int RBUF_OVR   = 14;
  localparam int XCSR_READY = 7;
  localparam int XCSR_IE    = 6;
  localparam int XCSR_MAINT = 2;

  localparam logic [12:0] CSR_BASE_DEF = 13'o17560;
  localparam logic [8:0]  VEC_RX_DEF   = 9'o060;
  localparam logic [8:0]  VEC_TX_DEF   = 9'o064;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    IAK  = 2'd3
  } bus_state_e;

  function automatic logic [15:0] vec_word(input logic [8:0] vec);
    return {7'b0, vec};
  endfunction

endpackage

// File: rtl/dl11_uart.sv
// 8N1 serial engine for the DL11: transmit shifter, receive sampler with a
// 2-flop input synchronizer, each driven by its own BAUD_DIV bit counter.
module dl11_uart
  import qbus_dl11_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd434
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       txd_o,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_strobe_o,
  output logic       rx_ferr_o
);

  localparam logic [15:0] FULL_M1 = BAUD_DIV - 16'd1;
  localparam logic [15:0] HALF_M1 = (BAUD_DIV >> 1) - 16'd1;

  logic        tx_busy_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic [9:0]  tx_sh_q;

  // Frame is {stop, data, start}; shifting in ones keeps the line idle-high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (!tx_busy_q) begin
      if (tx_start_i) begin
        tx_busy_q <= 1'b1;
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_cnt_q  <= '0;
        tx_bit_q  <= '0;
      end
    end else if (tx_cnt_q == FULL_M1) begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
      end else begin
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign tx_busy_o = tx_busy_q;
  assign txd_o     = ~tx_busy_q | tx_sh_q[0];

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic        rx_active_q;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_strobe_q, rx_ferr_q;

  // rx_bit_q: 0 = start-bit recheck at half period, 1..8 data, 9 stop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_strobe_q <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      rx_s1_q     <= rxd_i;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_strobe_q <= 1'b0;
      if (!rx_active_q) begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= '0;
          rx_bit_q    <= '0;
        end
      end else if (rx_bit_q == 4'd0) begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_q <= '0;
          if (rx_s2_q) rx_active_q <= 1'b0;
          else         rx_bit_q    <= 4'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + 16'd1;
        end
      end else if (rx_cnt_q == FULL_M1) begin
        rx_cnt_q <= '0;
        if (rx_bit_q == 4'd9) begin
          rx_active_q <= 1'b0;
          rx_strobe_q <= 1'b1;
          rx_ferr_q   <= ~rx_s2_q;
        end else begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
    end
  end

  assign rx_data_o   = rx_sh_q;
  assign rx_strobe_o = rx_strobe_q;
  assign rx_ferr_o   = rx_ferr_q;

endmodule

// File: rtl/qbus_dl11.sv
// DL11 console terminal slave on the F-11 QBUS: register window, IAK vectors
// and the serial engine. QBUS_DL11_MAINT_EN adds the XCSR maintenance loopback.
module qbus_dl11
  import qbus_dl11_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd434,
  parameter logic [12:0] CSR_BASE = CSR_BASE_DEF,
  parameter logic [8:0]  VEC_RX   = VEC_RX_DEF,
  parameter logic [8:0]  VEC_TX   = VEC_TX_DEF
) (
  input  logic        pin_clk,
  input  logic        pin_init,
  input  logic [15:0] qb_ad_in,
  output logic [15:0] qb_ad_out,
  output logic        qb_ad_oe,
  input  logic        qb_sync,
  input  logic        qb_bs,
  input  logic        qb_din,
  input  logic        qb_dout,
  input  logic        qb_wtbt,
  output logic        qb_rply,
  input  logic        qb_iako_in,
  output logic        qb_iako_out,
  output logic        qb_virq,
  input  logic        ser_rxd,
  output logic        ser_txd
);

  bus_state_e  state_q, state_d;
  logic        sync_q, din_q, sel_q, ack_q, iako_q;
  logic [2:0]  addr_q;
  logic [15:0] rdata_q, rd_mux;
  logic        rx_ie_q, tx_ie_q, done_q, ovr_q, err_q;
  logic [7:0]  rbuf_q;
  logic        lvl_rx_q, lvl_tx_q, req_rx_q, req_tx_q;
  logic        tx_start, tx_busy, rx_strobe, rx_ferr, uart_txd, rx_src, maint_bit;
  logic [7:0]  rx_data;
  logic        rd_start, iak_start, rbuf_rd, wr_en, grant_rx, grant_tx;
  logic        lvl_rx, lvl_tx, any_req, strobe_ok;
  logic        unused_hi;

  assign unused_hi = ^qb_ad_in[15:13];
  assign any_req   = req_rx_q | req_tx_q;
  assign rd_start  = (state_q == IDLE) && (state_d == RD);
  assign iak_start = (state_q == IDLE) && (state_d == IAK);
  assign rbuf_rd   = rd_start && (addr_q[2:1] == REG_RBUF);
  assign grant_rx  = iak_start && req_rx_q;
  assign grant_tx  = iak_start && !req_rx_q && req_tx_q;
  assign wr_en     = (state_q == WR) && !ack_q && qb_dout && !(qb_wtbt && addr_q[0]);
  assign tx_start  = wr_en && (addr_q[2:1] == REG_XBUF) && !tx_busy;
  assign lvl_rx    = done_q & rx_ie_q;
  assign lvl_tx    = ~tx_busy & tx_ie_q;

  always_comb begin
    state_d   = state_q;
    strobe_ok = qb_din;
    qb_ad_oe  = 1'b0;
    qb_rply   = 1'b0;
    qb_ad_out = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_q && qb_din)       state_d = RD;
        else if (sel_q && qb_dout) state_d = WR;
        else if (qb_iako_in && qb_din && !qb_sync && any_req) state_d = IAK;
      end
      RD, IAK: if (!qb_din) state_d = IDLE;
      WR: begin
        strobe_ok = qb_dout;
        if (!qb_dout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobe and INIT gate the pins directly so they fall in the same cycle.
    qb_ad_oe  = (state_q == RD || state_q == IAK) && qb_din && !pin_init;
    qb_rply   = ack_q && strobe_ok && !pin_init;
    qb_ad_out = qb_ad_oe ? rdata_q : '0;
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr_q[2:1])
      REG_RCSR: begin
        rd_mux[RCSR_DONE] = done_q;
        rd_mux[RCSR_IE]   = rx_ie_q;
      end
      REG_RBUF: begin
        rd_mux[RBUF_ERR] = err_q;
        rd_mux[RBUF_OVR] = ovr_q;
        rd_mux[7:0]      = rbuf_q;
      end
      REG_XCSR: begin
        rd_mux[XCSR_READY] = ~tx_busy;
        rd_mux[XCSR_IE]    = tx_ie_q;
        rd_mux[XCSR_MAINT] = maint_bit;
      end
      default: rd_mux = '0;
    endcase
  end

  // Read data and vectors are frozen at the start of the transfer so the
  // side effects of the read cannot disturb the value being driven.
  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      state_q <= IDLE;
      sync_q  <= 1'b0;
      din_q   <= 1'b0;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      iako_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= qb_sync;
      din_q   <= qb_din;
      ack_q   <= (state_q != IDLE) && (state_d != IDLE);
      if (qb_sync && !sync_q) begin
        addr_q <= qb_ad_in[2:0];
        sel_q  <= qb_bs && (qb_ad_in[12:3] == CSR_BASE[12:3]);
      end else if (!qb_sync) begin
        sel_q <= 1'b0;
      end
      if (rd_start)       rdata_q <= rd_mux;
      else if (iak_start) rdata_q <= vec_word(req_rx_q ? VEC_RX : VEC_TX);
      if (qb_din && !din_q) iako_q <= qb_iako_in & ~any_req;
      else if (!qb_iako_in) iako_q <= 1'b0;
    end
  end

  always_ff @(posedge pin_clk) begin
    if (pin_init) begin
      rx_ie_q  <= 1'b0;
      tx_ie_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      rbuf_q   <= '0;
      lvl_rx_q <= 1'b0;
      lvl_tx_q <= 1'b0;
      req_rx_q <= 1'b0;
      req_tx_q <= 1'b0;
    end else begin
      if (wr_en && addr_q[2:1] == REG_RCSR) rx_ie_q <= qb_ad_in[RCSR_IE];
      if (wr_en && addr_q[2:1] == REG_XCSR) tx_ie_q <= qb_ad_in[XCSR_IE];
      // A frame landing on the same cycle as an RBUF read wins without overrun.
      if (rx_strobe) begin
        rbuf_q <= rx_data;
        err_q  <= rx_ferr;
        done_q <= 1'b1;
        ovr_q  <= ovr_q | (done_q & ~rbuf_rd);
        if (rbuf_rd) ovr_q <= 1'b0;
      end else if (rbuf_rd) begin
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      lvl_rx_q <= lvl_rx;
      lvl_tx_q <= lvl_tx;
      if (!lvl_rx || grant_rx)  req_rx_q <= 1'b0;
      else if (!lvl_rx_q)       req_rx_q <= 1'b1;
      if (!lvl_tx || grant_tx)  req_tx_q <= 1'b0;
      else if (!lvl_tx_q)       req_tx_q <= 1'b1;
    end
  end

`ifdef QBUS_DL11_MAINT_EN
  logic maint_q;

  always_ff @(posedge pin_clk) begin
    if (pin_init) maint_q <= 1'b0;
    else if (wr_en && addr_q[2:1] == REG_XCSR) maint_q <= qb_ad_in[XCSR_MAINT];
  end

  assign maint_bit = maint_q;
  assign rx_src    = maint_q ? uart_txd : ser_rxd;
  assign ser_txd   = maint_q | uart_txd;
`else
  assign maint_bit = 1'b0;
  assign rx_src    = ser_rxd;
  assign ser_txd   = uart_txd;
`endif

  assign qb_virq     = any_req;
  assign qb_iako_out = iako_q;

  dl11_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk_i       (pin_clk),
    .reset_i     (pin_init),
    .tx_data_i   (qb_ad_in[7:0]),
    .tx_start_i  (tx_start),
    .tx_busy_o   (tx_busy),
    .txd_o       (uart_txd),
    .rxd_i       (rx_src),
    .rx_data_o   (rx_data),
    .rx_strobe_o (rx_strobe),
    .rx_ferr_o   (rx_ferr)
  );

endmodule

// File: tb/tb_qbus_dl11.sv
// Self-checking bench for qbus_dl11: directed bus cycles plus random serial
// traffic, checked against a register-level model and a serial frame decoder.
module tb_qbus_dl11;

  localparam int B = 16;
  localparam logic [15:0] A_RCSR = 16'o177560;
  localparam logic [15:0] A_RBUF = 16'o177562;
  localparam logic [15:0] A_XCSR = 16'o177564;
  localparam logic [15:0] A_XBUF = 16'o177566;

  logic        pin_clk = 1'b0;
  logic        pin_init;
  logic [15:0] qb_ad_in;
  logic [15:0] qb_ad_out;
  logic        qb_ad_oe, qb_sync, qb_bs, qb_din, qb_dout, qb_wtbt, qb_rply;
  logic        qb_iako_in, qb_iako_out, qb_virq, ser_rxd, ser_txd;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    logic       framing;
  } txFrame_t;
  txFrame_t txq[$];

  // Register-level view of the terminal, updated from the programmer's model.
  logic       mDone, mOvr, mErr, mRxIe, mTxIe, mReady;
  logic [7:0] mData;

  always #5 pin_clk = ~pin_clk;

  qbus_dl11 #(.BAUD_DIV(16'(B))) dut (
    .pin_clk     (pin_clk),
    .pin_init    (pin_init),
    .qb_ad_in    (qb_ad_in),
    .qb_ad_out   (qb_ad_out),
    .qb_ad_oe    (qb_ad_oe),
    .qb_sync     (qb_sync),
    .qb_bs       (qb_bs),
    .qb_din      (qb_din),
    .qb_dout     (qb_dout),
    .qb_wtbt     (qb_wtbt),
    .qb_rply     (qb_rply),
    .qb_iako_in  (qb_iako_in),
    .qb_iako_out (qb_iako_out),
    .qb_virq     (qb_virq),
    .ser_rxd     (ser_rxd),
    .ser_txd     (ser_txd)
  );

  function automatic logic [15:0] expRcsr();
    return {8'b0, mDone, mRxIe, 6'b0};
  endfunction

  function automatic logic [15:0] expXcsr();
    return {8'b0, mReady, mTxIe, 6'b0};
  endfunction

  function automatic logic [15:0] expRbuf();
    return {mErr, mOvr, 6'b0, mData};
  endfunction

  task automatic modelReset();
    mDone = 0; mOvr = 0; mErr = 0; mRxIe = 0; mTxIe = 0; mReady = 1; mData = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %06o expected %06o", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    qb_ad_in = '0; qb_sync = 0; qb_bs = 0; qb_din = 0; qb_dout = 0;
    qb_wtbt = 0; qb_iako_in = 0;
  endtask

  task automatic waitRply(input string tag);
    bit got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge pin_clk);
      if (qb_rply === 1'b1) got = 1;
    end
    checkOutput({tag, "_rply"}, {15'b0, qb_rply}, 16'd1);
  endtask

  task automatic busRead(input logic [15:0] addr, input string tag,
                         input logic [15:0] expected);
    @(negedge pin_clk); qb_ad_in = addr; qb_bs = 1; qb_sync = 1;
    @(negedge pin_clk); qb_din = 1;
    waitRply(tag);
    checkOutput({tag, "_oe"}, {15'b0, qb_ad_oe}, 16'd1);
    checkOutput(tag, qb_ad_out, expected);
    qb_din = 0;
    #1 checkOutput({tag, "_drop"}, {14'b0, qb_ad_oe, qb_rply}, 16'd0);
    @(negedge pin_clk); qb_sync = 0; qb_bs = 0;
    @(negedge pin_clk);
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [15:0] data,
                          input logic byteMode, input string tag);
    @(negedge pin_clk); qb_ad_in = addr; qb_bs = 1; qb_sync = 1;
    @(negedge pin_clk); qb_ad_in = data; qb_dout = 1; qb_wtbt = byteMode;
    waitRply(tag);
    qb_dout = 0; qb_wtbt = 0;
    @(negedge pin_clk); qb_sync = 0; qb_bs = 0;
    @(negedge pin_clk);
  endtask

  task automatic iakCycle(input logic [15:0] vec, input logic virqAfter,
                          input string tag);
    @(negedge pin_clk); qb_iako_in = 1; qb_din = 1;
    waitRply(tag);
    checkOutput(tag, qb_ad_out, vec);
    checkOutput({tag, "_iako"}, {15'b0, qb_iako_out}, 16'd0);
    qb_din = 0;
    @(negedge pin_clk); qb_iako_in = 0;
    @(negedge pin_clk);
    checkOutput({tag, "_virq"}, {15'b0, qb_virq}, {15'b0, virqAfter});
  endtask

  task automatic strobeUnsel(input logic [15:0] addr, input logic bs,
                             input logic isWrite, input string tag);
    logic seen = 0;
    @(negedge pin_clk); qb_ad_in = addr; qb_bs = bs; qb_sync = 1;
    @(negedge pin_clk); qb_din = !isWrite; qb_dout = isWrite;
    for (int i = 0; i < 8; i++) begin
      @(negedge pin_clk);
      seen = seen | qb_rply | qb_ad_oe;
    end
    checkOutput(tag, {15'b0, seen}, 16'd0);
    qb_din = 0; qb_dout = 0;
    @(negedge pin_clk); qb_sync = 0; qb_bs = 0;
    @(negedge pin_clk);
  endtask

  task automatic sendSerial(input logic [7:0] d, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge pin_clk) ser_rxd = f[i];
      repeat (B - 1) @(negedge pin_clk);
    end
    @(negedge pin_clk) ser_rxd = 1;
    repeat (4) @(negedge pin_clk);
    if (mDone) mOvr = 1;
    mData = d; mErr = ~stopBit; mDone = 1;
  endtask

  task automatic waitTxFrame(input logic [7:0] expected, input string tag);
    txFrame_t fr;
    for (int i = 0; i < 14 * B && txq.size() == 0; i++) @(negedge pin_clk);
    checkOutput({tag, "_cnt"}, 16'(txq.size()), 16'd1);
    if (txq.size() > 0) begin
      fr = txq.pop_front();
      checkOutput(tag, {7'b0, fr.framing, fr.data}, {8'h01, expected});
    end
  endtask

  // Line receiver on ser_txd: samples mid-bit, one queue entry per frame.
  initial begin
    logic prev, ok;
    logic [7:0] d;
    txFrame_t fr;
    prev = 1;
    forever begin
      @(negedge pin_clk);
      if (prev === 1'b1 && ser_txd === 1'b0) begin
        ok = 1;
        repeat (B / 2) @(negedge pin_clk);
        if (ser_txd !== 1'b0) ok = 0;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge pin_clk);
          d[i] = ser_txd;
        end
        repeat (B) @(negedge pin_clk);
        if (ser_txd !== 1'b1) ok = 0;
        fr.data = d;
        fr.framing = ok;
        txq.push_back(fr);
      end
      prev = ser_txd;
    end
  end

  initial begin
    logic [7:0] b, b2;
    logic       stopBit;
    int         n;

    applyStimulus();
    ser_rxd  = 1;
    pin_init = 1;
    modelReset();
    repeat (3) @(negedge pin_clk);
    pin_init = 0;
    @(negedge pin_clk);
    checkOutput("rst_txd", {15'b0, ser_txd}, 16'd1);
    checkOutput("rst_pins", {13'b0, qb_virq, qb_rply, qb_iako_out}, 16'd0);
    busRead(A_XCSR, "rst_xcsr", 16'o000200);
    busRead(A_RCSR, "rst_rcsr", 16'o000000);

    busWrite(A_XBUF, 16'o000101, 0, "tx41_wr");
    mReady = 0;
    busRead(A_XCSR, "tx41_busy", expXcsr());
    waitTxFrame(8'h41, "tx41_frame");
    repeat (B) @(negedge pin_clk);
    mReady = 1;
    busRead(A_XCSR, "tx41_ready", expXcsr());

    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      busWrite(A_XBUF, {8'($urandom), b}, 0, "txr_wr");
      mReady = 0;
      busRead(A_XCSR, "txr_busy", expXcsr());
      waitTxFrame(b, "txr_frame");
      repeat (B) @(negedge pin_clk);
      mReady = 1;
      busRead(A_XCSR, "txr_ready", expXcsr());
    end

    busWrite(A_XBUF, 16'h00C3, 0, "txd_wr1");
    busWrite(A_XBUF, 16'h003C, 0, "txd_wr2");
    waitTxFrame(8'hC3, "txd_first");
    repeat (14 * B) @(negedge pin_clk);
    checkOutput("txd_dropped", 16'(txq.size()), 16'd0);
    mReady = 1;

    sendSerial(8'h5A, 1);
    busRead(A_RCSR, "rx5a_rcsr", 16'o000200);
    busRead(A_RBUF, "rx5a_rbuf", 16'o000132);
    mDone = 0; mOvr = 0;
    busRead(A_RCSR, "rx5a_rcsr2", 16'o000000);

    sendSerial(8'h11, 1);
    sendSerial(8'h22, 1);
    busRead(A_RBUF, "rx_ovr_rbuf", expRbuf());
    mDone = 0; mOvr = 0;
    busRead(A_RBUF, "rx_ovr_clr", expRbuf());

    for (int k = 0; k < 6; k++) begin
      mRxIe = 1'($urandom_range(0, 1));
      busWrite(A_RCSR, {9'b0, mRxIe, 6'b0}, 0, "rxr_ie");
      n = $urandom_range(1, 2);
      for (int j = 0; j < n; j++) begin
        b2 = 8'($urandom);
        stopBit = ($urandom_range(0, 3) != 0);
        sendSerial(b2, stopBit);
      end
      busRead(A_RCSR, "rxr_rcsr", expRcsr());
      busRead(A_RBUF, "rxr_rbuf", expRbuf());
      mDone = 0; mOvr = 0;
      busRead(A_RCSR, "rxr_rcsr2", expRcsr());
    end
    mRxIe = 0;
    busWrite(A_RCSR, 16'o000000, 0, "rxr_ie_off");

    busWrite(A_XCSR + 16'd1, 16'o000100, 1, "byte_odd");
    busRead(A_XCSR, "byte_odd_xcsr", expXcsr());
    busWrite(A_RCSR, 16'o000100, 1, "byte_even");
    mRxIe = 1;
    busRead(A_RCSR, "byte_even_rcsr", expRcsr());
    busWrite(A_RCSR, 16'o000000, 0, "byte_clr");
    mRxIe = 0;

    busWrite(A_XCSR, 16'o000100, 0, "irq_tx_ie");
    mTxIe = 1;
    checkOutput("irq_tx_virq", {15'b0, qb_virq}, 16'd1);
    busRead(A_XCSR, "irq_tx_xcsr", expXcsr());
    iakCycle(16'o000064, 0, "iak_tx");
    busWrite(A_XCSR, 16'o000000, 0, "irq_tx_off");
    mTxIe = 0;

    busWrite(A_RCSR, 16'o000100, 0, "irq_rx_ie");
    mRxIe = 1;
    sendSerial(8'h33, 1);
    busWrite(A_XCSR, 16'o000100, 0, "irq_both_ie");
    mTxIe = 1;
    checkOutput("irq_both_virq", {15'b0, qb_virq}, 16'd1);
    iakCycle(16'o000060, 1, "iak_both_rx");
    iakCycle(16'o000064, 0, "iak_both_tx");
    busRead(A_RBUF, "irq_rbuf", expRbuf());
    mDone = 0; mOvr = 0;
    busWrite(A_RCSR, 16'o000000, 0, "irq_rx_off");
    busWrite(A_XCSR, 16'o000000, 0, "irq_tx_off2");
    mRxIe = 0; mTxIe = 0;

    strobeUnsel(16'o177570, 1, 0, "unsel_rd570");
    strobeUnsel(16'o177570, 1, 1, "unsel_wr570");
    strobeUnsel(A_RCSR, 0, 0, "unsel_mem");
    busRead(16'o177567, "win_top", 16'o000000);
    @(negedge pin_clk); qb_iako_in = 1; qb_din = 1;
    repeat (4) @(negedge pin_clk);
    checkOutput("iak_none_pass", {14'b0, qb_iako_out, qb_rply}, 16'd2);
    qb_din = 0;
    @(negedge pin_clk); qb_iako_in = 0;
    @(negedge pin_clk);

    busWrite(A_RCSR, 16'o000100, 0, "init_rx_ie");
    busWrite(A_XCSR, 16'o000100, 0, "init_tx_ie");
    mRxIe = 1; mTxIe = 1;
    busWrite(A_XBUF, 16'h00F0, 0, "init_tx_wr");
    repeat (3 * B) @(negedge pin_clk);
    @(negedge pin_clk); qb_ad_in = A_XCSR; qb_bs = 1; qb_sync = 1;
    @(negedge pin_clk); qb_din = 1;
    waitRply("init_rd");
    pin_init = 1;
    @(negedge pin_clk);
    checkOutput("init_pins", {13'b0, qb_rply, qb_ad_oe, ser_txd}, 16'd1);
    pin_init = 0;
    applyStimulus();
    modelReset();
    repeat (12 * B) @(negedge pin_clk);
    txq.delete();
    checkOutput("init_virq", {15'b0, qb_virq}, 16'd0);
    busRead(A_XCSR, "init_xcsr", expXcsr());
    busRead(A_RCSR, "init_rcsr", expRcsr());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qbus_dl11.md
Name: qbus_dl11

Overview:
- Synthesizable DL11-style console terminal slave on the external QBUS of the F-11 replica.
- Consumes F-11 bus cycles: decodes the I/O page window 177560–177567, serves the four terminal registers, and supplies interrupt vectors on IAKO.
- Converts register traffic to and from an 8N1 serial line.
- The top level inverts the bus pins, so every bus port here is active-high.

Parameters:
BAUD_DIV, 16'd434, clocks per serial bit (50 MHz / 115200); legal range 16..65535
CSR_BASE, 13'o17560, I/O-page offset of RCSR; window is CSR_BASE..CSR_BASE+7
VEC_RX, 9'o060, receiver interrupt vector
VEC_TX, 9'o064, transmitter interrupt vector

Ports:
pin_clk  in  1  system clock, all logic on rising edge
pin_init  in  1  synchronous active-high reset (bus INIT)
qb_ad_in  in  16  address/data from bus
qb_ad_out  out  16  read data / vector
qb_ad_oe  out  1  drive enable for qb_ad_out
qb_sync  in  1  address strobe
qb_bs  in  1  I/O page select, qualified by qb_sync rise
qb_din  in  1  read / vector strobe
qb_dout  in  1  write strobe
qb_wtbt  in  1  byte write when high during qb_dout
qb_rply  out  1  transfer reply
qb_iako_in  in  1  interrupt acknowledge, daisy-chain input
qb_iako_out  out  1  interrupt acknowledge, daisy-chain output
qb_virq  out  1  vectored interrupt request
ser_rxd  in  1  serial input, idle high, asynchronous
ser_txd  out  1  serial output, idle high

Behaviour:
- Reset values: all outputs 0 except ser_txd=1. TX ready=1; RX done, both IE bits, overrun and both requests=0; FSM in IDLE.
- Address latch: on the cycle qb_sync rises, latch qb_ad_in[12:0] and qb_bs. sel=qb_bs & addr[12:3]==CSR_BASE[12:3]. sel clears when qb_sync falls.
- Bus FSM:
  - IDLE→RD when sel&qb_din. qb_ad_oe=1 in the first RD cycle; qb_rply=1 from the next cycle.
  - IDLE→WR when sel&qb_dout. Register updates on the first WR cycle; qb_rply=1 from the next cycle.
  - IDLE→IAK when qb_iako_in&qb_din&~qb_sync&(req_rx|req_tx). Drives the vector and clears the granted request; qb_rply follows one cycle later.
  - RD/WR/IAK→IDLE on the cycle the strobe (qb_din or qb_dout) is low. qb_rply and qb_ad_oe drop in that same cycle.
  - Strobe on an unselected cycle: no reply, no drive.
- Register map:
  - RCSR +0: bit7 done (RO), bit6 IE (RW).
  - RBUF +2: bit15 error, bit14 overrun, [7:0] data. Reading clears done and overrun. Writes are ignored.
  - XCSR +4: bit7 ready (RO), bit6 IE (RW).
  - XBUF +6: write [7:0] starts TX and clears ready; write while not ready is dropped. Reads return 0.
  - Unused bits read 0. Byte writes use qb_ad_in[7:0] for even addresses and are ignored for odd addresses.
- Interrupts:
  - req_x sets on the rising edge of (flag_x & ie_x) and clears on IAK grant or when (flag_x & ie_x) falls.
  - qb_virq=req_rx|req_tx. RX wins when both are pending; TX stays pending.
  - qb_iako_out=qb_iako_in & ~(req_rx|req_tx), latched at the qb_din rise.
- Serial transmit: start bit, 8 data bits LSB first, stop bit; each bit lasts BAUD_DIV clocks. ready=1 in the cycle after the stop bit ends.
- Serial receive:
  - Input passes through a 2-flop synchronizer.
  - Falling edge starts a frame; the start bit is re-checked at BAUD_DIV/2 (a glitch aborts the frame).
  - Data bits are sampled every BAUD_DIV after that.
  - Stop bit=0 sets error. A completed frame while done=1 sets overrun and overwrites data.
  - Simultaneous RBUF read and frame completion: the new frame wins, done stays 1, and no overrun is flagged.
- pin_init mid-frame aborts TX (ser_txd=1 next cycle), aborts RX, drops qb_rply/qb_ad_oe immediately and returns the FSM to IDLE.

Optional Feature:
- QBUS_DL11_MAINT_EN defined: XCSR bit2 is a RW maintenance bit. When set, the RX input is taken from internal txd (ser_rxd ignored) and ser_txd is held at 1.
- Macro undefined: XCSR bit2 reads 0, writes are ignored, and there is no loopback path.

Decomposition:
- Package qbus_dl11_pkg: register offsets, CSR bit indices, FSM state enum (IDLE, RD, WR, IAK), default vectors.
- One sub-module, dl11_uart: TX/RX shifters, baud counters, synchronizer. Interface: tx_data/tx_start/tx_busy, rx_data/rx_strobe/rx_ferr.

Test Plan:
- Reset, then read 177564 → 000200; read 177560 → 000000; ser_txd=1; qb_virq=0.
- Write XBUF=000101 → XCSR reads 000000; ser_txd emits 0,1,0,0,0,0,0,1,0,1 at BAUD_DIV spacing; XCSR reads 000200 again after 10·BAUD_DIV clocks.
- Drive frame 0x5A on ser_rxd → RCSR reads 000200, RBUF reads 000132, RCSR then 000000. Two frames without a read → RBUF bit14 set.
- Write XCSR=000100 while ready → qb_virq=1. IAK cycle → qb_ad_out=000064, qb_rply, then qb_virq=0 and qb_iako_out stays 0.
- Strobes at 177570 and at a memory address (qb_bs=0) → no qb_rply and qb_ad_oe=0. IAK with no pending request → qb_iako_out=1.
- Assert pin_init mid-TX and during an active read → ser_txd=1 and qb_rply=0 next cycle; all CSRs back at reset values.
